// File: rtl/sram_if_pkg.sv
// Shared encodings for the CPU-side SRAM-like request interface: access sizes,
// responder FSM states, and the size/address-to-byte-strobe helper.
package sram_if_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef struct packed {
        logic [3:0] strb;
        logic       mis;
    } strb_t;

    // A misaligned access always returns an empty strobe so it can never write.
    function automatic strb_t size2strb(input logic [1:0] size, input logic [1:0] addr_lo);
        strb_t r;
        r.strb = 4'b0000;
        r.mis  = 1'b0;
        case (size)
            SZ_BYTE: r.strb = 4'b0001 << addr_lo;
            SZ_HALF: begin
                r.strb = addr_lo[1] ? 4'b1100 : 4'b0011;
                r.mis  = addr_lo[0];
            end
            SZ_WORD: begin
                r.strb = 4'b1111;
                r.mis  = (addr_lo != 2'b00);
            end
            default: r.mis = 1'b1;
        endcase
        if (r.mis) r.strb = 4'b0000;
        return r;
    endfunction

endpackage

// File: rtl/sram_bytewe_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port;
// reads return the word as it was before a same-cycle write.
module sram_bytewe_ram #(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             en,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [0:(1<<IDX_W)-1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
            rdata_q <= mem[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sram_like_slave.sv
// SRAM-like slave: accepts one request at a time and answers from local RAM
// exactly LATENCY cycles after acceptance with a one-cycle data_ok pulse.
module sram_like_slave
    import sram_if_pkg::*;
#(
    parameter int IDX_W   = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [1:0]       size_q, size_d;
    logic [IDX_W+1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             mis_q, mis_d;

    logic             is_idle;
    logic             access;
    logic             acc_wr;
    logic [1:0]       acc_size;
    logic [IDX_W+1:0] acc_addr;
    logic [31:0]      acc_wdata;
    strb_t            acc_chk;
    logic [3:0]       ram_we;
    logic [31:0]      ram_rdata;
    logic             addr_hi_unused;

    assign is_idle        = (state_q == S_IDLE);
    assign addr_hi_unused = ^addr[31:IDX_W+2];

    // With LATENCY == 1 the RAM is accessed in the accept cycle itself, so the
    // access fields come straight from the request inputs while idle.
    assign acc_wr    = is_idle ? wr            : wr_q;
    assign acc_size  = is_idle ? size          : size_q;
    assign acc_addr  = is_idle ? addr[IDX_W+1:0] : addr_q;
    assign acc_wdata = is_idle ? wdata         : wdata_q;
    assign acc_chk   = size2strb(acc_size, acc_addr[1:0]);
    assign ram_we    = acc_chk.strb & {4{access & acc_wr}};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    size_d  = size;
                    addr_d  = addr[IDX_W+1:0];
                    wdata_d = wdata;
                    cnt_d   = LAT_M1;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    access  = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        mis_d = access ? acc_chk.mis : mis_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
        end
    end

    sram_bytewe_ram #(.IDX_W(IDX_W)) u_ram (
        .clk   (clk),
        .en    (access),
        .we    (ram_we),
        .idx   (acc_addr[IDX_W+1:2]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    // Response outputs derive from the async-reset state, so reset clears them at once.
    assign addr_ok = is_idle & req;
    assign busy    = req | ~is_idle;
    assign data_ok = (state_q == S_RESP);
    assign err     = data_ok & mis_q;
    assign rdata   = (data_ok & ~wr_q & ~mis_q) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: two instances (LATENCY 2 and 3) driven in lockstep
// and compared against a word-array memory model built from the access rules.
module tb_sram_like_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;

    logic        addr_ok2, data_ok2, err2, busy2;
    logic [31:0] rdata2;
    logic        addr_ok3, data_ok3, err3, busy3;
    logic [31:0] rdata3;

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_mem [0:1023];

    always #5 clk = ~clk;

    sram_like_slave #(.IDX_W(10), .LATENCY(2)) dut_l2 (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok2), .data_ok(data_ok2), .rdata(rdata2), .err(err2), .busy(busy2)
    );

    sram_like_slave #(.IDX_W(10), .LATENCY(3)) dut_l3 (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok3), .data_ok(data_ok3), .rdata(rdata3), .err(err3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic lane_hit(input logic [1:0] sz, input logic [31:0] a, input int b);
        if (sz == 2'd0) return (b == int'(a[1:0]));
        if (sz == 2'd1) return (b / 2 == int'(a[1]));
        return 1'b1;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        w = ref_mem[a[11:2]];
        for (int b = 0; b < 4; b++)
            if (lane_hit(sz, a, b)) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[a[11:2]] = w;
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    endtask

    task automatic scramble_inputs();
        req = 1'b0; wr = $urandom_range(0, 1); size = 2'($urandom_range(0, 3));
        addr = $urandom; wdata = $urandom;
    endtask

    // One full transaction; data_ok must appear at exactly t+2 and t+3 respectively.
    task automatic txn(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic        m;
        logic [31:0] exp_rd;
        m = is_mis(sz, a);
        exp_rd = (m || w) ? 32'd0 : ref_mem[a[11:2]];
        drive(w, sz, a, d);
        @(negedge clk);
        check("addr_ok_l2", addr_ok2, 1);
        check("addr_ok_l3", addr_ok3, 1);
        @(posedge clk); #1;
        scramble_inputs();
        if (w && !m) model_store(sz, a, d);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("data_ok_l2", data_ok2, (k == 2));
            check("data_ok_l3", data_ok3, (k == 3));
            check("busy_l3", busy3, (k <= 3));
            if (k == 2) begin
                check("rdata_l2", rdata2, exp_rd);
                check("err_l2", err2, m);
            end
            if (k == 3) begin
                check("rdata_l3", rdata3, exp_rd);
                check("err_l3", err3, m);
            end
        end
    endtask

    task automatic no_pulse(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check(tag, {data_ok2, data_ok3}, 2'b00);
        end
    endtask

    initial begin
        // reset state
        #12;
        check("rst_data_ok", {data_ok2, data_ok3}, 2'b00);
        check("rst_rdata_l2", rdata2, 0);
        check("rst_rdata_l3", rdata3, 0);
        check("rst_err", {err2, err3}, 2'b00);
        check("rst_addr_ok", {addr_ok2, addr_ok3}, 2'b00);
        check("rst_busy", {busy2, busy3}, 2'b00);
        @(negedge clk); rst = 1'b0;

        // word round trip
        txn(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
        txn(1'b0, 2'd2, 32'h100, 32'h0);

        // byte and halfword merges
        txn(1'b1, 2'd2, 32'h104, 32'h11223344);
        txn(1'b1, 2'd0, 32'h106, 32'h00AA0000);
        txn(1'b0, 2'd2, 32'h104, 32'h0);
        check("byte_merge_model", ref_mem[32'h104 >> 2], 32'h11AA3344);
        txn(1'b1, 2'd2, 32'h104, 32'h11223344);
        txn(1'b1, 2'd1, 32'h104, 32'h0000BEEF);
        txn(1'b0, 2'd2, 32'h104, 32'h0);
        check("half_merge_model", ref_mem[32'h104 >> 2], 32'h1122BEEF);

        // misaligned accesses leave the word untouched
        txn(1'b1, 2'd2, 32'h108, 32'h01020304);
        txn(1'b1, 2'd1, 32'h109, 32'hFFFFFFFF);
        txn(1'b1, 2'd2, 32'h10A, 32'hFFFFFFFF);
        txn(1'b1, 2'd3, 32'h108, 32'hFFFFFFFF);
        txn(1'b0, 2'd2, 32'h10A, 32'h0);
        txn(1'b0, 2'd2, 32'h108, 32'h0);
        check("mis_model", ref_mem[32'h108 >> 2], 32'h01020304);

        // address wrap
        txn(1'b1, 2'd2, 32'h1000, 32'hCAFEF00D);
        txn(1'b0, 2'd2, 32'h0, 32'h0);
        check("wrap_model", ref_mem[0], 32'hCAFEF00D);

        // reset mid-WAIT aborts a store
        txn(1'b1, 2'd2, 32'h200, 32'h55AA55AA);
        drive(1'b1, 2'd2, 32'h200, 32'h12345678);
        @(posedge clk); #1;
        scramble_inputs();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_data_ok", {data_ok2, data_ok3}, 2'b00);
        check("abort_busy", {busy2, busy3}, 2'b00);
        @(negedge clk); rst = 1'b0;
        no_pulse("abort_no_pulse", 4);
        txn(1'b0, 2'd2, 32'h200, 32'h0);

        // reset during RESP drops the response without a clock edge
        drive(1'b0, 2'd2, 32'h200, 32'h0);
        @(posedge clk); #1;
        scramble_inputs();
        @(negedge clk);
        @(negedge clk);
        check("resp_data_ok_before", data_ok2, 1);
        check("resp_rdata_before", rdata2, 32'h55AA55AA);
        #1 rst = 1'b1;
        #1;
        check("async_data_ok", {data_ok2, data_ok3}, 2'b00);
        check("async_rdata_l2", rdata2, 0);
        check("async_rdata_l3", rdata3, 0);
        check("async_err", {err2, err3}, 2'b00);
        @(negedge clk); rst = 1'b0;
        no_pulse("async_no_pulse", 4);

        // back-pressure: req held high, accepts every LATENCY+1 cycles
        ref_mem[32'h300 >> 2] = 32'hA5A5A5A5;
        txn(1'b1, 2'd2, 32'h300, 32'hA5A5A5A5);
        drive(1'b0, 2'd2, 32'h300, 32'h0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("bp_addr_ok_l2", addr_ok2, (k % 3 == 0));
            check("bp_addr_ok_l3", addr_ok3, (k % 4 == 0));
            check("bp_busy", {busy2, busy3}, 2'b11);
            if (k % 3 == 2) check("bp_rdata_l2", rdata2, 32'hA5A5A5A5);
        end
        @(posedge clk); #1;
        scramble_inputs();
        repeat (5) @(negedge clk);

        // randomized traffic over a small pool of initialised words
        for (int i = 0; i < 8; i++) txn(1'b1, 2'd2, 32'h100 + 32'(i * 4), $urandom);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = $urandom;
            a[11:2] = 10'(32'h40 + $urandom_range(0, 7));
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
